// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-port arbiter.
//   DBG_CMD_W / DBG_W  : command and address/data widths
//   DBG_CMD_NOP        : command value meaning "no request"
//   DBG_TIMEOUT_DATA   : read data returned to a master whose transaction was aborted
//   dbg_arb_state_t    : arbiter FSM states
//   dbg_is_req()       : true when a command value is a request
package dbg_pkg;

  localparam int unsigned DBG_CMD_W = 8;
  localparam int unsigned DBG_W     = 32;

  localparam logic [DBG_CMD_W-1:0] DBG_CMD_NOP      = 8'h00;
  localparam logic [DBG_W-1:0]     DBG_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dbg_arb_state_t;

  function automatic logic dbg_is_req(input logic [DBG_CMD_W-1:0] cmd);
    return (cmd != DBG_CMD_NOP);
  endfunction

endpackage

// File: rtl/dbg_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
//   req_i[1:0] : request vector (bit n = master n)
//   last_i     : index of the master granted most recently
//   gnt_o[1:0] : one-hot winner, 2'b00 when nobody requests
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // Lone requester wins outright; on contention the master that was not last wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dbg_arbiter.sv
// dbg_arbiter: shares the single core debug port between two debug masters
// (host pins = master 0, on-chip bridge = master 1), one transaction at a time,
// round-robin on contention. All outputs are registered.
//   sys_clk_i, po_rstn_i           : clock, asynchronous active-low reset
//   mX_cmd_i/addr_i/data_i         : master X request (cmd 8'h00 = NOP)
//   mX_data_o, mX_ready_o          : master X read data and one-cycle completion
//   dbg_cmd_o/addr_o/data_o        : registered request toward the core
//   dbg_data_i, dbg_ready_i        : core response
//   grant_o                        : one-hot owner, 2'b00 when idle
//   timeout_o                      : one-cycle pulse on an aborted transaction
// Optional feature: define DBG_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES busy cycles without a core response.
module dbg_arbiter
  import dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 sys_clk_i,
  input  logic                 po_rstn_i,
  input  logic [DBG_CMD_W-1:0] m0_cmd_i,
  input  logic [DBG_W-1:0]     m0_addr_i,
  input  logic [DBG_W-1:0]     m0_data_i,
  output logic [DBG_W-1:0]     m0_data_o,
  output logic                 m0_ready_o,
  input  logic [DBG_CMD_W-1:0] m1_cmd_i,
  input  logic [DBG_W-1:0]     m1_addr_i,
  input  logic [DBG_W-1:0]     m1_data_i,
  output logic [DBG_W-1:0]     m1_data_o,
  output logic                 m1_ready_o,
  output logic [DBG_CMD_W-1:0] dbg_cmd_o,
  output logic [DBG_W-1:0]     dbg_addr_o,
  output logic [DBG_W-1:0]     dbg_data_o,
  input  logic [DBG_W-1:0]     dbg_data_i,
  input  logic                 dbg_ready_i,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dbg_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  dbg_arb_state_t       state_q, state_d;
  logic                 last_q, last_d;
  logic [1:0]           grant_q, grant_d;
  logic [DBG_CMD_W-1:0] cmd_q, cmd_d;
  logic [DBG_W-1:0]     addr_q, addr_d;
  logic [DBG_W-1:0]     wdata_q, wdata_d;
  logic [DBG_W-1:0]     m0_data_q, m0_data_d;
  logic [DBG_W-1:0]     m1_data_q, m1_data_d;
  logic                 m0_ready_q, m0_ready_d;
  logic                 m1_ready_q, m1_ready_d;
  logic                 timeout_q, timeout_d;

  logic [1:0]           pick_s;
  logic                 expired_s;
  logic                 done_s;
  logic [DBG_W-1:0]     resp_s;

  rr_pick2 u_pick (
    .req_i  ({dbg_is_req(m1_cmd_i), dbg_is_req(m0_cmd_i)}),
    .last_i (last_q),
    .gnt_o  (pick_s)
  );

`ifdef DBG_ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  // Busy counter: held at zero outside a transaction, counts each BUSY cycle.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    case (state_q)
      IDLE:    busy_cnt_d = {CNT_W{1'b0}};
      BUSY:    busy_cnt_d = busy_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      default: busy_cnt_d = busy_cnt_q;
    endcase
  end

  // Busy counter register.
  always_ff @(posedge sys_clk_i or negedge po_rstn_i) begin
    if (!po_rstn_i) begin
      busy_cnt_q <= {CNT_W{1'b0}};
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Counter shows the cycles already spent, so the last allowed BUSY cycle is CNT_LAST.
  assign expired_s = (state_q == BUSY) && (busy_cnt_q == CNT_LAST);
`else
  assign expired_s = 1'b0;
`endif

  // A real core response beats a simultaneous expiry.
  assign done_s = dbg_ready_i | expired_s;
  assign resp_s = dbg_ready_i ? dbg_data_i : DBG_TIMEOUT_DATA;

  // Next-state and output-register logic of the arbiter FSM.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_data_d  = m0_data_q;
    m1_data_d  = m1_data_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_s != 2'b00) begin
          grant_d = pick_s;
          last_d  = pick_s[1];
          cmd_d   = pick_s[1] ? m1_cmd_i  : m0_cmd_i;
          addr_d  = pick_s[1] ? m1_addr_i : m0_addr_i;
          wdata_d = pick_s[1] ? m1_data_i : m0_data_i;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (done_s) begin
          if (grant_q[1]) begin
            m1_data_d = resp_s;
          end else begin
            m0_data_d = resp_s;
          end
          m0_ready_d = grant_q[0];
          m1_ready_d = grant_q[1];
          timeout_d  = ~dbg_ready_i;
          cmd_d      = DBG_CMD_NOP;
          state_d    = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        cmd_d   = DBG_CMD_NOP;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; pointer resets to master 1 so master 0 wins first.
  always_ff @(posedge sys_clk_i or negedge po_rstn_i) begin
    if (!po_rstn_i) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      grant_q    <= 2'b00;
      cmd_q      <= DBG_CMD_NOP;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      m0_data_q  <= 32'h0000_0000;
      m1_data_q  <= 32'h0000_0000;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_data_q  <= m0_data_d;
      m1_data_q  <= m1_data_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dbg_cmd_o  = cmd_q;
  assign dbg_addr_o = addr_q;
  assign dbg_data_o = wdata_q;
  assign m0_data_o  = m0_data_q;
  assign m1_data_o  = m1_data_q;
  assign m0_ready_o = m0_ready_q;
  assign m1_ready_o = m1_ready_q;
  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_dbg_arbiter.sv
// Testbench for dbg_arbiter. A transaction-level reference model (owner index,
// busy-cycle count, round-robin memory) is advanced on every rising edge and
// compared with all DUT outputs on every falling edge; directed scenarios add
// hand-computed literal expectations. Masters and the core are emulated
// reactively at the falling edge. Define DBG_ARB_TIMEOUT_EN to exercise abort.
module tb_dbg_arbiter;

  localparam int TO_CYC = 8;
`ifdef DBG_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  m0_cmd = 8'h00, m1_cmd = 8'h00;
  logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0, m0_wd = 32'h0, m1_wd = 32'h0;
  logic [31:0] m0_data_o, m1_data_o, dbg_addr_o, dbg_data_o;
  logic        m0_ready_o, m1_ready_o, timeout_o;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_data_i = 32'h0;
  logic        dbg_ready_i = 1'b0;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  dbg_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .sys_clk_i (clk),        .po_rstn_i (rst_n),
    .m0_cmd_i  (m0_cmd),     .m0_addr_i (m0_addr),   .m0_data_i (m0_wd),
    .m0_data_o (m0_data_o),  .m0_ready_o(m0_ready_o),
    .m1_cmd_i  (m1_cmd),     .m1_addr_i (m1_addr),   .m1_data_i (m1_wd),
    .m1_data_o (m1_data_o),  .m1_ready_o(m1_ready_o),
    .dbg_cmd_o (dbg_cmd_o),  .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
    .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i),
    .grant_o   (grant_o),    .timeout_o (timeout_o)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model (transaction level) ----------------
  int          owner;       // -1: nobody owns the port
  int          last_w;      // master served most recently
  int          busy_cnt;
  bit          finishing;   // completion reported, port released next edge
  logic [1:0]  e_grant;
  logic [7:0]  e_cmd;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] e_mdata [2];
  bit          e_ready [2];
  bit          e_to;

  task automatic model_reset();
    owner = -1; last_w = 1; busy_cnt = 0; finishing = 1'b0;
    e_grant = 2'b00; e_cmd = 8'h00; e_addr = 32'h0; e_wdata = 32'h0;
    e_mdata[0] = 32'h0; e_mdata[1] = 32'h0;
    e_ready[0] = 1'b0; e_ready[1] = 1'b0; e_to = 1'b0;
  endtask

  task automatic model_complete(input logic [31:0] d, input bit aborted);
    e_mdata[owner] = d;
    e_ready[owner] = 1'b1;
    e_to = aborted;
    e_cmd = 8'h00;
    finishing = 1'b1;
  endtask

  task automatic model_step();
    bit r0, r1;
    int w;
    e_ready[0] = 1'b0; e_ready[1] = 1'b0; e_to = 1'b0;
    if (finishing) begin
      finishing = 1'b0; owner = -1; e_grant = 2'b00;
    end else if (owner >= 0) begin
      if (dbg_ready_i) begin
        model_complete(dbg_data_i, 1'b0);
      end else begin
        busy_cnt++;
        if (TO_EN && busy_cnt >= TO_CYC) model_complete(32'hDEAD_BEEF, 1'b1);
      end
    end else begin
      r0 = (m0_cmd != 8'h00);
      r1 = (m1_cmd != 8'h00);
      if (r0 || r1) begin
        if (r0 && r1) w = 1 - last_w;
        else          w = r0 ? 0 : 1;
        owner = w; last_w = w; busy_cnt = 0;
        e_grant = (w == 0) ? 2'b01 : 2'b10;
        e_cmd   = (w == 0) ? m0_cmd  : m1_cmd;
        e_addr  = (w == 0) ? m0_addr : m1_addr;
        e_wdata = (w == 0) ? m0_wd   : m1_wd;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- environment state ----------------
  int          rem [2];       // further back-to-back requests per master
  bit          pend [2];      // re-raise request on next falling edge
  int          rdy_cnt [2];
  bit          core_en = 1'b1;
  int          core_lat = 3;
  int          busy_n = 0;
  int          txn_n = 1;
  bit          spur = 1'b0;
  logic [1:0]  prev_g = 2'b00;
  logic [1:0]  glog [$];

  // One clock: model at the rising edge, compare + drive at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    chk("grant",     32'(grant_o),    32'(e_grant));
    chk("dbg_cmd",   32'(dbg_cmd_o),  32'(e_cmd));
    chk("dbg_addr",  dbg_addr_o,      e_addr);
    chk("dbg_data",  dbg_data_o,      e_wdata);
    chk("m0_data",   m0_data_o,       e_mdata[0]);
    chk("m1_data",   m1_data_o,       e_mdata[1]);
    chk("m0_ready",  32'(m0_ready_o), 32'(e_ready[0]));
    chk("m1_ready",  32'(m1_ready_o), 32'(e_ready[1]));
    chk("timeout",   32'(timeout_o),  32'(e_to));
    if (grant_o !== prev_g) begin
      glog.push_back(grant_o);
      prev_g = grant_o;
    end
    // masters: re-raise pending requests, drop cmd at the end of the ready cycle
    if (pend[0]) begin m0_cmd = 8'h10; m0_addr = 32'h2000 + 32'(rem[0]); rem[0]--; pend[0] = 1'b0; end
    if (pend[1]) begin m1_cmd = 8'h11; m1_addr = 32'h2100 + 32'(rem[1]); rem[1]--; pend[1] = 1'b0; end
    if (m0_ready_o) begin rdy_cnt[0]++; m0_cmd = 8'h00; if (rem[0] > 0) pend[0] = 1'b1; end
    if (m1_ready_o) begin rdy_cnt[1]++; m1_cmd = 8'h00; if (rem[1] > 0) pend[1] = 1'b1; end
    // core: answer core_lat cycles into a transaction
    if (dbg_cmd_o != 8'h00) begin
      if (core_en) begin
        busy_n++;
        if (busy_n == core_lat) begin
          dbg_ready_i = 1'b1; dbg_data_i = 32'hCAFE_0000 + 32'(txn_n); txn_n++;
        end else begin
          dbg_ready_i = 1'b0;
        end
      end else begin
        dbg_ready_i = 1'b0;
      end
    end else begin
      busy_n = 0;
      dbg_ready_i = spur;
      dbg_data_i = spur ? 32'h5555_AAAA : 32'h0;
    end
  endtask

  task automatic wait_ready(input int m, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      n++;
      if ((m == 0) ? m0_ready_o : m1_ready_o) return;
    end
    tests++; fails++;
    $display("FAIL wait_ready_m%0d: no ready within %0d cycles", m, budget);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_grant",   32'(grant_o),   32'h0);
    chk("rst_dbg_cmd", 32'(dbg_cmd_o), 32'h0);
    chk("rst_m0_data", m0_data_o,      32'h0);
    chk("rst_m1_data", m1_data_o,      32'h0);
    chk("rst_ready",   32'({m1_ready_o, m0_ready_o, timeout_o}), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    glog.delete(); prev_g = 2'b00;
  endtask

  initial begin
    int n, base;
    logic [1:0] nz [$];
    rem[0] = 0; rem[1] = 0; pend[0] = 1'b0; pend[1] = 1'b0;
    rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    #1;
    do_reset();
    tick();

    // single request from m0
    m0_cmd = 8'h01; m0_addr = 32'h0000_1000; m0_wd = 32'h0000_00A5;
    tick();
    chk("single_cmd_c1",  32'(dbg_cmd_o), 32'h01);
    chk("single_addr_c1", dbg_addr_o,     32'h0000_1000);
    chk("single_grant",   32'(grant_o),   32'h1);
    wait_ready(0, 20, n);
    chk("single_latency", 32'(n), 32'd3);
    chk("single_m0_data", m0_data_o, 32'hCAFE_0001);
    chk("single_m1_rdy",  32'(m1_ready_o), 32'h0);
    tick();
    chk("single_rdy_once", 32'(m0_ready_o), 32'h0);
    chk("single_idle_gnt", 32'(grant_o), 32'h0);

    // simultaneous requests after reset: m0 first, then m1
    do_reset();
    m0_cmd = 8'h02; m0_addr = 32'h0000_1100;
    m1_cmd = 8'h03; m1_addr = 32'h0000_1200; m1_wd = 32'h1234_5678;
    wait_ready(1, 40, n);
    tick(); tick();
    chk("simul_log_len", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      chk("simul_g0", 32'(glog[0]), 32'h1);
      chk("simul_g1", 32'(glog[1]), 32'h0);
      chk("simul_g2", 32'(glog[2]), 32'h2);
      chk("simul_g3", 32'(glog[3]), 32'h0);
    end

    // fairness: both keep requesting for 6 transactions
    glog.delete(); rdy_cnt[0] = 0; rdy_cnt[1] = 0; core_lat = 1;
    rem[0] = 2; rem[1] = 2;
    m0_cmd = 8'h10; m0_addr = 32'h2003;
    m1_cmd = 8'h11; m1_addr = 32'h2103;
    for (int i = 0; i < 120 && (rdy_cnt[0] + rdy_cnt[1]) < 6; i++) tick();
    tick(); tick();
    chk("fair_m0_count", 32'(rdy_cnt[0]), 32'd3);
    chk("fair_m1_count", 32'(rdy_cnt[1]), 32'd3);
    foreach (glog[i]) if (glog[i] != 2'b00) nz.push_back(glog[i]);
    chk("fair_grants", 32'(nz.size()), 32'd6);
    foreach (nz[i]) chk($sformatf("fair_g%0d", i), 32'(nz[i]), (i % 2 == 0) ? 32'h1 : 32'h2);

    // spurious core ready while idle
    base = rdy_cnt[0] + rdy_cnt[1];
    spur = 1'b1; tick(); spur = 1'b0;
    tick(); tick(); tick();
    chk("spur_no_ready", 32'(rdy_cnt[0] + rdy_cnt[1] - base), 32'd0);
    chk("spur_grant", 32'(grant_o), 32'h0);

    // reset during BUSY with m1 pending
    core_en = 1'b0;
    m0_cmd = 8'h20; m0_addr = 32'h0000_3000;
    tick(); tick();
    m1_cmd = 8'h21; m1_addr = 32'h0000_3100; m1_wd = 32'h0000_0077;
    tick();
    chk("rstb_grant_busy", 32'(grant_o), 32'h1);
    m0_cmd = 8'h00;
    do_reset();
    core_en = 1'b1; core_lat = 2; base = txn_n;
    tick();
    chk("rstb_m1_cmd",  32'(dbg_cmd_o), 32'h21);
    chk("rstb_m1_wd",   dbg_data_o,     32'h0000_0077);
    wait_ready(1, 20, n);
    chk("rstb_m1_data", m1_data_o, 32'hCAFE_0000 + 32'(base));
    tick(); tick();

    // core never answers
    core_en = 1'b0; base = rdy_cnt[0];
    m0_cmd = 8'h30; m0_addr = 32'h0000_4000;
`ifdef DBG_ARB_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 30 && !m0_ready_o; i++) begin
      tick();
      if (grant_o != 2'b00 && !m0_ready_o) n++;
    end
    chk("to_busy_cycles", 32'(n), 32'd8);
    chk("to_m0_ready", 32'(m0_ready_o), 32'h1);
    chk("to_pulse",    32'(timeout_o),  32'h1);
    chk("to_m0_data",  m0_data_o,       32'hDEAD_BEEF);
    tick();
    chk("to_pulse_end", 32'(timeout_o), 32'h0);
    tick(); tick();
`else
    for (int i = 0; i < 20; i++) tick();
    chk("hang_no_ready", 32'(rdy_cnt[0] - base), 32'd0);
    chk("hang_grant",    32'(grant_o),   32'h1);
    chk("hang_timeout",  32'(timeout_o), 32'h0);
    m0_cmd = 8'h00;
    do_reset();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
